// File: rtl/retry_arbiter_pkg.sv
// Shared helpers for the retry round-robin arbiter.
package retry_arbiter_pkg;

  // Round-robin pointer advance, wrapping from n-1 back to 0.
  function automatic int unsigned rr_wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/retry_credit_counter.sv
// Up/down saturating in-flight counter; simultaneous inc and dec leave it unchanged.
module retry_credit_counter #(
  parameter int unsigned MaxCount = 2,
  parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                underflow_o
);

  logic [CntWidth-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      count_q <= count_q + CntWidth'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_q <= count_q - CntWidth'(1);
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CntWidth'(MaxCount));
  assign underflow_o = dec_i & ~inc_i & (count_q == '0);

endmodule

// File: rtl/retry_rr_arbiter.sv
// Round-robin arbiter in front of a retry-protected pipeline, with per-requester
// outstanding limits and index-steered result return.
module retry_rr_arbiter
  import retry_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter type         DataType       = logic,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned IdxWidth      = $clog2(NumReq),
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  DataType [NumReq-1:0]              req_data_i,
  input  logic    [NumReq-1:0]              req_valid_i,
  output logic    [NumReq-1:0]              req_ready_o,
  output DataType                           data_o,
  output logic    [IdxWidth-1:0]            req_idx_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  input  DataType                           result_data_i,
  input  logic    [IdxWidth-1:0]            result_req_idx_i,
  input  logic                              result_valid_i,
  output logic                              result_ready_o,
  output DataType [NumReq-1:0]              rsp_data_o,
  output logic    [NumReq-1:0]              rsp_valid_o,
  input  logic    [NumReq-1:0]              rsp_ready_i,
  output logic    [NumReq-1:0][CntWidth-1:0] outstanding_o,
  output logic                              err_o
);

  logic [IdxWidth-1:0] rr_q, grant_q, search_idx, grant;
  logic                lock_q, err_q;
  logic                any_eligible, lock_hold, lock_violation;
  logic                idx_in_range, sel_rsp_ready;
  logic [NumReq-1:0]   eligible, full, underflow, inc, dec;
  logic [NumReq-1:0][CntWidth-1:0] count;
  int unsigned         cand;

  for (genvar i = 0; i < NumReq; i++) begin : g_cnt
    retry_credit_counter #(
      .MaxCount (MaxOutstanding),
      .CntWidth (CntWidth)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (inc[i]),
      .dec_i       (dec[i]),
      .count_o     (count[i]),
      .full_o      (full[i]),
      .underflow_o (underflow[i])
    );
  end

  assign eligible     = req_valid_i & ~full;
  assign any_eligible = |eligible;

  // Scan offsets high to low so the last write is the first eligible at/after rr_q.
  always_comb begin
    search_idx = '0;
    cand       = 0;
    for (int unsigned off = NumReq; off > 0; off--) begin
      cand = (32'(rr_q) + off - 32'd1) % NumReq;
      if (eligible[IdxWidth'(cand)]) search_idx = IdxWidth'(cand);
    end
  end

  // A locked requester that drops valid releases the lock in the same cycle,
  // so the stale index is never presented or counted.
  assign lock_hold      = lock_q & req_valid_i[grant_q];
  assign lock_violation = lock_q & ~req_valid_i[grant_q];
  assign grant          = lock_hold ? grant_q : search_idx;
  assign valid_o        = any_eligible | lock_hold;
  assign data_o         = req_data_i[grant];
  assign req_idx_o      = grant;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = valid_o & ready_i & (grant == IdxWidth'(i));
    end
  end
  assign inc = req_ready_o;

  assign idx_in_range = (32'(result_req_idx_i) < NumReq);

  always_comb begin
    sel_rsp_ready = 1'b0;
    rsp_valid_o   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_data_o[i] = result_data_i;
      if (result_req_idx_i == IdxWidth'(i)) begin
        sel_rsp_ready  = rsp_ready_i[i];
        rsp_valid_o[i] = result_valid_i;
      end
    end
  end

  // Out-of-range indices are accepted and dropped so the pipeline never stalls.
  assign result_ready_o = result_valid_i & (idx_in_range ? sel_rsp_ready : 1'b1);
  assign dec            = rsp_valid_o & {NumReq{result_ready_o}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= valid_o & ~ready_i;
      grant_q <= grant;
      if (valid_o && ready_i) begin
        rr_q <= IdxWidth'(rr_wrap_inc(32'(grant), NumReq));
      end
      err_q <= err_q | lock_violation | (|underflow) | (result_valid_i & ~idx_in_range);
    end
  end

  assign outstanding_o = count;
  assign err_o         = err_q;

endmodule

// File: tb/tb_retry_rr_arbiter.sv
// Randomized and directed checking of retry_rr_arbiter against a rule-level model.
module tb_retry_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0][7:0]     req_data;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [7:0]            data_o;
  logic [1:0]            req_idx;
  logic                  valid;
  logic                  ready;
  logic [7:0]            result_data;
  logic [1:0]            result_idx;
  logic                  result_valid;
  logic                  result_ready;
  logic [N-1:0][7:0]     rsp_data;
  logic [N-1:0]          rsp_valid;
  logic [N-1:0]          rsp_ready;
  logic [N-1:0][1:0]     outstanding;
  logic                  err;

  retry_rr_arbiter #(
    .NumReq         (N),
    .DataType       (logic [7:0]),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_data_i       (req_data),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .data_o           (data_o),
    .req_idx_o        (req_idx),
    .valid_o          (valid),
    .ready_i          (ready),
    .result_data_i    (result_data),
    .result_req_idx_i (result_idx),
    .result_valid_i   (result_valid),
    .result_ready_o   (result_ready),
    .rsp_data_o       (rsp_data),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .outstanding_o    (outstanding),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: in-flight count per requester, next-in-line pointer,
  // the requester a stalled offer is held for, and the sticky error.
  int m_cnt[N];
  int m_rr;
  bit m_lock;
  int m_gq;
  bit m_err;

  int e_g;
  bit e_valid;
  int e_req_ready;
  int e_rsp_valid;
  bit e_result_ready;
  int e_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    req_valid    = '0;
    req_data     = '0;
    ready        = 1'b0;
    result_valid = 1'b0;
    result_idx   = '0;
    result_data  = '0;
    rsp_ready    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_rr = 0; m_lock = 0; m_gq = 0; m_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_outputs();
    int j;
    bit hold;
    e_g  = -1;
    hold = m_lock && req_valid[2'(m_gq)];
    if (hold) e_g = m_gq;
    else begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (e_g < 0 && req_valid[2'(j)] && m_cnt[j] < MAXO) e_g = j;
      end
    end
    e_valid        = (e_g >= 0);
    e_req_ready    = (e_valid && ready) ? (1 << e_g) : 0;
    e_rsp_valid    = result_valid ? (1 << int'(result_idx)) : 0;
    e_result_ready = result_valid && rsp_ready[result_idx];
    e_out = 0;
    for (int k = 0; k < N; k++) e_out |= m_cnt[k] << (2 * k);
  endtask

  // Checks the current cycle, advances the model across the clock edge and
  // returns at the next falling edge with the handshaken request withdrawn.
  task automatic tick();
    bit hs;
    int nc;
    #1;
    model_outputs();
    check("valid_o", 32'(valid), 32'(e_valid));
    if (e_valid) begin
      check("req_idx_o", 32'(req_idx), e_g);
      check("data_o", 32'(data_o), 32'(req_data[2'(e_g)]));
    end
    check("req_ready_o", 32'(req_ready), e_req_ready);
    check("rsp_valid_o", 32'(rsp_valid), e_rsp_valid);
    check("result_ready_o", 32'(result_ready), 32'(e_result_ready));
    check("outstanding_o", 32'(outstanding), e_out);
    check("err_o", 32'(err), 32'(m_err));
    if (result_valid) check("rsp_data_o", 32'(rsp_data[result_idx]), 32'(result_data));
    @(posedge clk);
    if (m_lock && !req_valid[2'(m_gq)]) m_err = 1;
    for (int k = 0; k < N; k++) begin
      nc = m_cnt[k] + ((e_req_ready >> k) & 1)
           - ((e_result_ready && int'(result_idx) == k) ? 1 : 0);
      if (nc < 0) begin
        nc = 0;
        m_err = 1;
      end
      m_cnt[k] = nc;
    end
    hs = e_valid && ready;
    if (hs) m_rr = (e_g + 1) % N;
    m_lock = e_valid && !ready;
    m_gq   = e_g;
    @(negedge clk);
    if (hs) req_valid[2'(e_g)] = 1'b0;
  endtask

  initial begin
    int cl[$];

    // Reset then idle
    do_reset();
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) tick();

    // All requesters valid, pipeline always ready: 0,1,2,3 twice, then all masked
    for (int c = 0; c < 10; c++) begin
      req_valid = '1;
      for (int k = 0; k < N; k++) req_data[2'(k)] = 8'($urandom);
      ready = 1'b1;
      #1;
      check("seq_valid", 32'(valid), (c < 8) ? 32'd1 : 32'd0);
      if (c < 8) check("seq_idx", 32'(req_idx), 32'(c % 4));
      tick();
    end

    // Full requester 0 gets a result back and becomes eligible the next cycle
    idle_inputs();
    req_valid[0] = 1'b1;
    req_data[0]  = 8'h5a;
    ready        = 1'b1;
    result_valid = 1'b1;
    result_idx   = 2'd0;
    result_data  = 8'hc3;
    rsp_ready    = '1;
    #1;
    check("full_masked_valid", 32'(valid), 32'd0);
    tick();
    result_valid = 1'b0;
    #1;
    check("refill_valid", 32'(valid), 32'd1);
    check("refill_idx", 32'(req_idx), 32'd0);
    check("refill_cnt0", 32'(outstanding[0]), 32'd1);
    tick();

    // Stall on requester 2 holds the offer while requester 1 waits
    do_reset();
    req_valid[2] = 1'b1;
    req_data[2]  = 8'hb2;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        req_valid[1] = 1'b1;
        req_data[1]  = 8'h71;
      end
      #1;
      check("lock_idx", 32'(req_idx), 32'd2);
      check("lock_data", 32'(data_o), 32'hb2);
      tick();
    end
    ready = 1'b1;
    #1;
    check("lock_release_idx", 32'(req_idx), 32'd2);
    tick();
    #1;
    check("after_lock_idx", 32'(req_idx), 32'd1);
    tick();

    // Same-cycle request and response on index 1 leave its count unchanged
    do_reset();
    req_valid[1] = 1'b1;
    req_data[1]  = 8'h11;
    ready        = 1'b1;
    tick();
    req_valid[1] = 1'b1;
    req_data[1]  = 8'h22;
    result_valid = 1'b1;
    result_idx   = 2'd1;
    result_data  = 8'h99;
    rsp_ready    = 4'b0010;
    tick();
    idle_inputs();
    #1;
    check("same_cycle_cnt1", 32'(outstanding[1]), 32'd1);
    check("same_cycle_err", 32'(err), 32'd0);
    tick();

    // Result for an idle requester: delivered, count stays 0, error sticks
    result_valid = 1'b1;
    result_idx   = 2'd3;
    result_data  = 8'he7;
    rsp_ready    = '1;
    #1;
    check("underflow_rsp_valid3", 32'(rsp_valid[3]), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("underflow_cnt3", 32'(outstanding[3]), 32'd0);
    check("underflow_err", 32'(err), 32'd1);
    repeat (3) tick();
    do_reset();
    #1;
    check("err_cleared_by_reset", 32'(err), 32'd0);

    // Randomized traffic with out-of-order results
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[2'(k)] && $urandom_range(0, 2) == 0) begin
          req_valid[2'(k)] = 1'b1;
          req_data[2'(k)]  = 8'($urandom);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      cl.delete();
      for (int k = 0; k < N; k++) if (m_cnt[k] > 0) cl.push_back(k);
      if (cl.size() > 0 && $urandom_range(0, 1) == 1) begin
        result_valid = 1'b1;
        result_idx   = 2'(cl[$urandom_range(0, cl.size() - 1)]);
      end else begin
        result_valid = 1'b0;
        result_idx   = 2'($urandom);
      end
      result_data = 8'($urandom);
      rsp_ready   = 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/retry_rr_arbiter.md
Name: retry_rr_arbiter

Overview:
Round-robin arbiter that lets NumReq independent requesters share one retry-protected processing pipeline (retry start stage, pipeline, retry end stage). It tags each granted operation with its requester index and returns completed results, which may arrive out of order, to the owning requester. It also limits outstanding operations per requester so no requester can exhaust the retry ID space.

Parameters:
NumReq, 4, number of requesters (>=2).
DataType, logic, payload type for requests and results.
MaxOutstanding, 2, max in-flight operations per requester (>=1).
IdxWidth, $clog2(NumReq), localparam, width of requester index.
CntWidth, $clog2(MaxOutstanding+1), localparam, width of per-requester outstanding counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_data_i  in  NumReq x DataType  request payload per requester
req_valid_i  in  NumReq  request valid per requester
req_ready_o  out  NumReq  request ready per requester
data_o  out  DataType  payload toward pipeline
req_idx_o  out  IdxWidth  requester index travelling with payload
valid_o  out  1  valid toward pipeline
ready_i  in  1  ready from pipeline
result_data_i  in  DataType  completed result from pipeline
result_req_idx_i  in  IdxWidth  requester index returned with result
result_valid_i  in  1  result valid
result_ready_o  out  1  result ready
rsp_data_o  out  NumReq x DataType  result per requester (all driven with result_data_i)
rsp_valid_o  out  NumReq  result valid per requester
rsp_ready_i  in  NumReq  result ready per requester
outstanding_o  out  NumReq x CntWidth  current in-flight count per requester
err_o  out  1  sticky protocol error

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Reset clears rr pointer to 0, lock to 0, all counters to 0 and err_o to 0.
- Out of reset: valid_o=0, req_ready_o=0, rsp_valid_o=0, result_ready_o=0, err_o=0.
- Request path is combinational, with zero-cycle latency and no buffering.
- eligible[i] = req_valid_i[i] & (outstanding[i] < MaxOutstanding).
- Grant is the first eligible index at or after rr_q, wrapping modulo NumReq.
- valid_o = any eligible, or lock_q. data_o and req_idx_o follow the grant.
- req_ready_o[g] = ready_i for the granted index g only. All other indices get 0.
- Lock rule: if valid_o & ~ready_i, lock_q<=1 and grant_q<=g. While lock_q=1, the grant is forced to grant_q, so data_o and req_idx_o stay stable. Lock clears on handshake.
- Upstream must keep req_valid_i asserted once raised until handshake. A requester dropping valid while locked is a protocol violation: set err_o, clear lock.
- On handshake (valid_o & ready_i): rr_q <= (g+1) mod NumReq (wrap from NumReq-1 to 0), and outstanding[g] is incremented.
- Response path is combinational:
  - rsp_valid_o[i] = result_valid_i & (result_req_idx_i==i).
  - result_ready_o = rsp_ready_i[result_req_idx_i].
- On response handshake, outstanding[idx] is decremented.
- If a request and a response for the same index handshake in the same cycle, the counter is unchanged.
- Error cases:
  - Response for a requester whose count is 0: counter saturates at 0, err_o is set, the result is still delivered.
  - result_req_idx_i >= NumReq (non-power-of-2 NumReq): result_ready_o=1, result is dropped, err_o is set.
  - err_o clears only on reset.
- A counter at MaxOutstanding masks that requester. It becomes eligible again in the cycle after a response handshake decrements it.
- Reset mid-operation: all in-flight bookkeeping is lost. The pipeline and retry stages must share the same reset.
- Ordering: results may arrive out of order. The arbiter never reorders or buffers them.

Decomposition:
- Package retry_arbiter_pkg holds a helper function for the wrap-around increment of the rr pointer. The parametric sizing (IdxWidth, CntWidth) stays as localparams, because they depend on module parameters.
- One sub-module, retry_credit_counter: up/down saturating counter with inc, dec, count_o, full_o and underflow_o. It is instantiated NumReq times.
- Priority selection and lock logic stay in the top module.

Test Plan:
- Reset then idle, with all req_valid_i=0 -> valid_o=0, err_o=0, outstanding_o all 0.
- All 4 requesters valid, ready_i=1, no results -> grants go 0,1,2,3. At 0,1,2,3, each requester is then masked and valid_o=0 from cycle 8.
- Requester 2 granted with ready_i=0 for 3 cycles while requester 1 raises valid -> req_idx_o stays 2 and data_o is stable. Requester 2 handshakes in cycle 4, then 1 is granted next (it follows rr order from 3 after wrap).
- Requester 0 at count 2 (full) and result_req_idx_i=0 handshakes -> count drops to 1, and requester 0 is granted the following cycle if valid.
- In the same cycle, a request handshake for idx 1 and a result handshake for idx 1 -> outstanding_o[1] is unchanged, err_o=0.
- Result with idx 3 while outstanding[3]=0 -> rsp_valid_o[3]=1, count stays 0, err_o=1 and stays set until reset.
